// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one external combinational ALU between two requesters.
// Optional grant statistics outputs are enabled by defining ALU_SCHED_STATS_EN.
module alu_rr_scheduler #(
    parameter int DATA_W      = 4,
    parameter int RES_W       = 8,  // must equal 2*DATA_W
    parameter int HOLD_CYCLES = 1   // legal range 1..15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*DATA_W-1:0]   req_a,
    input  logic [2*DATA_W-1:0]   req_b,
    input  logic [3:0]            req_op,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [1:0]            alu_s,
    input  logic [RES_W-1:0]      alu_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [RES_W-1:0]      rsp_data,
    output logic                  rsp_id,
`ifdef ALU_SCHED_STATS_EN
    output logic [15:0]           grant_cnt0,
    output logic [15:0]           grant_cnt1,
`endif
    output logic [1:0]            state_dbg
);

    // Handshakes: a request transfers on a cycle where req_valid[i] && req_ready[i];
    // a response transfers on a cycle where rsp_valid && rsp_ready. Requesters hold
    // valid and operands stable until they see ready.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t              state;
    state_t              state_nxt;
    logic                last;
    logic [3:0]          hold_cnt;
    logic                grant_vld;
    logic                grant_id;
    logic                accept;
    logic                hold_done;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [1:0]          sel_op;

    // With both requesters valid the one not served last wins; reset sets last=1.
    always_comb begin
        grant_vld = |req_valid;
        grant_id  = (req_valid == 2'b11) ? ~last : req_valid[1];
        accept    = (state == S_IDLE) && grant_vld;
        hold_done = (hold_cnt == HOLD_LAST);
        sel_a     = grant_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
        sel_b     = grant_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
        sel_op    = grant_id ? req_op[3:2] : req_op[1:0];
    end

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    state_nxt = S_EXEC;
                    // rst_n gating keeps the pulse low while reset is asserted
                    req_ready[grant_id] = rst_n;
                end
            end
            S_EXEC: begin
                if (hold_done) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= 1'b1;
            hold_cnt  <= 4'd0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= 2'b00;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
        end else begin
            if (accept) begin
                alu_a    <= sel_a;
                alu_b    <= sel_b;
                alu_s    <= sel_op;
                rsp_id   <= grant_id;
                last     <= grant_id;
                hold_cnt <= 4'd0;
            end
            if (state == S_EXEC) begin
                if (hold_done) begin
                    hold_cnt  <= 4'd0;
                    rsp_data  <= alu_y;
                    rsp_valid <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + 4'd1;
                end
            end
            if ((state == S_RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
        end else if (accept) begin
            if (!grant_id && (grant_cnt0 != 16'hFFFF)) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (grant_id && (grant_cnt1 != 16'hFFFF)) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end
    end
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed scenarios plus random traffic against a
// transaction-level model of the scheduler and an external ALU model.
module tb_alu_rr_scheduler;

    localparam int DATA_W = 4;
    localparam int RES_W  = 8;
    localparam int HOLD   = 1;

    logic                clk;
    logic                rst_n;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_a;
    logic [2*DATA_W-1:0] req_b;
    logic [3:0]          req_op;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [1:0]          alu_s;
    logic [RES_W-1:0]    alu_y;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [RES_W-1:0]    rsp_data;
    logic                rsp_id;
    logic [1:0]          state_dbg;
`ifdef ALU_SCHED_STATS_EN
    logic [15:0]         grant_cnt0;
    logic [15:0]         grant_cnt1;
`endif

    alu_rr_scheduler #(.DATA_W(DATA_W), .RES_W(RES_W), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
`ifdef ALU_SCHED_STATS_EN
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: 00 add, 01 mul, 10 concat, 11 shift-left of A by B.
    function automatic logic [RES_W-1:0] alu_fn(logic [3:0] a, logic [3:0] b, logic [1:0] s);
        int r;
        case (s)
            2'b00:   r = a + b;
            2'b01:   r = a * b;
            2'b10:   r = a * 16 + b;
            default: r = a * (2 ** b);
        endcase
        return RES_W'(r);
    endfunction

    assign alu_y = alu_fn(alu_a, alu_b, alu_s);

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- model state ----------------
    logic [RES_W:0] exp_q[$];      // {id, result} of accepted, unanswered ops
    bit             m_busy;
    int             m_rsp_at;
    bit             m_last;
    logic [3:0]     m_a, m_b;
    logic [1:0]     m_s;
    int             m_cnt[2];
    int             grant_log[$];

    task automatic model_reset();
        m_busy = 0; m_rsp_at = 0; m_last = 1;
        m_a = 0; m_b = 0; m_s = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        exp_q.delete();
    endtask

    // ---------------- driver state ----------------
    bit         p_valid[2];
    logic [3:0] p_a[2], p_b[2];
    logic [1:0] p_op[2];
    bit         keep_mode, rr_mode;

    task automatic apply();
        req_valid = {p_valid[1], p_valid[0]};
        req_a     = {p_a[1], p_a[0]};
        req_b     = {p_b[1], p_b[0]};
        req_op    = {p_op[1], p_op[0]};
    endtask

    task automatic new_op(int i);
        p_valid[i] = 1;
        p_a[i]  = 4'($urandom_range(0, 15));
        p_b[i]  = 4'($urandom_range(0, 15));
        p_op[i] = 2'($urandom_range(0, 3));
    endtask

    task automatic set_op(int i, int a, int b, int op);
        p_valid[i] = 1; p_a[i] = 4'(a); p_b[i] = 4'(b); p_op[i] = 2'(op);
    endtask

    // ---------------- observation capture for directed checks ----------------
    int         obs_first_rsp, acc_cyc, rdy0_cnt, rv_cnt, rdy_any_cnt, last_grant;
    logic [7:0] obs_data;
    logic       obs_id;

    task automatic reset_obs();
        obs_first_rsp = -1; acc_cyc = -1; rdy0_cnt = 0; rv_cnt = 0;
        rdy_any_cnt = 0; last_grant = -1; obs_data = 0; obs_id = 0;
    endtask

    // One clock cycle: check outputs at negedge, advance model at posedge, then drive.
    task automatic cycle();
        logic [1:0]     exp_rdy;
        bit             exp_rv;
        int             g;
        logic [RES_W:0] head;
        @(negedge clk);
        exp_rdy = 2'b00;
        g = -1;
        if (!m_busy) begin
            if (req_valid == 2'b11) g = 1 - int'(m_last);
            else if (req_valid[0]) g = 0;
            else if (req_valid[1]) g = 1;
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_rv = m_busy && (cyc >= m_rsp_at);
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
            head = exp_q[0];
            check("rsp_data", 32'(rsp_data), 32'(head[RES_W-1:0]));
            check("rsp_id", 32'(rsp_id), 32'(head[RES_W]));
        end
        check("alu_a", 32'(alu_a), 32'(m_a));
        check("alu_b", 32'(alu_b), 32'(m_b));
        check("alu_s", 32'(alu_s), 32'(m_s));
        if (rsp_valid === 1'b1) begin
            rv_cnt++;
            if (obs_first_rsp < 0) begin
                obs_first_rsp = cyc; obs_data = rsp_data; obs_id = rsp_id;
            end
        end
        if (req_ready[0] === 1'b1) rdy0_cnt++;
        if (req_ready !== 2'b00) rdy_any_cnt++;
        if (g >= 0) begin
            acc_cyc = cyc;
            last_grant = g;
            grant_log.push_back(g);
            m_a = p_a[g]; m_b = p_b[g]; m_s = p_op[g];
            exp_q.push_back({1'(g), alu_fn(p_a[g], p_b[g], p_op[g])});
            m_last = 1'(g);
            m_cnt[g]++;
        end
        @(posedge clk);
        cyc++;
        if (exp_rv && rsp_ready) begin
            void'(exp_q.pop_front());
            m_busy = 0;
        end
        if (g >= 0) begin
            m_busy = 1;
            m_rsp_at = cyc + HOLD;
        end
        #1;
        if (g >= 0) begin
            if (keep_mode) new_op(g);
            else p_valid[g] = 0;
        end
        if (rr_mode) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_valid[i] && $urandom_range(0, 2) == 0) new_op(i);
                else if (p_valid[i] && $urandom_range(0, 15) == 0) p_valid[i] = 0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        apply();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int start;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        keep_mode = 0; rr_mode = 0;
        p_valid[0] = 0; p_valid[1] = 0;
        for (int i = 0; i < 2; i++) begin p_a[i] = 0; p_b[i] = 0; p_op[i] = 0; end
        apply();
        model_reset();
        reset_obs();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_alu", 32'({alu_a, alu_b, alu_s}), 32'h0);
        rst_n = 1'b1;

        // Single req0 add 3+5
        reset_obs();
        set_op(0, 3, 5, 0);
        apply();
        run(6);
        check("t1_latency", 32'(obs_first_rsp - acc_cyc), 32'(HOLD + 1));
        check("t1_data", 32'(obs_data), 32'h08);
        check("t1_id", 32'(obs_id), 32'h0);
        check("t1_ready_pulses", 32'(rdy0_cnt), 32'd1);

        // req1 mul 15*15
        reset_obs();
        set_op(1, 15, 15, 1);
        apply();
        run(6);
        check("t2_data", 32'(obs_data), 32'hE1);
        check("t2_id", 32'(obs_id), 32'h1);

        // Both valid continuously: alternation starting with requester 0
        keep_mode = 1;
        new_op(0); new_op(1);
        apply();
        start = grant_log.size();
        for (int i = 0; i < 40 && grant_log.size() < start + 4; i++) cycle();
        check("t3_grants_seen", 32'(grant_log.size() >= start + 4), 32'd1);
        if (grant_log.size() >= start + 4) begin
            for (int i = 0; i < 4; i++) check("t3_grant_order", 32'(grant_log[start + i]), 32'(i % 2));
        end
        keep_mode = 0;
        p_valid[0] = 0; p_valid[1] = 0;
        apply();
        run(6);

        // Backpressure in RESP with a competing request pending
        rsp_ready = 1'b0;
        new_op(0); new_op(1);
        apply();
        run(2);
        reset_obs();
        run(5);
        check("t4_rsp_held", 32'(rv_cnt), 32'd5);
        check("t4_no_accept", 32'(rdy_any_cnt), 32'd0);
        rsp_ready = 1'b1;
        run(10);

        // Reset while EXEC: op discarded, tie goes to requester 0 afterwards
        set_op(1, 7, 9, 0);
        apply();
        cycle();
        rst_n = 1'b0;
        #1;
        check("t5_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("t5_rst_rsp_data", 32'(rsp_data), 32'h0);
        check("t5_rst_alu", 32'({alu_a, alu_b, alu_s}), 32'h0);
        check("t5_rst_rsp_id", 32'(rsp_id), 32'h0);
        check("t5_rst_ready", 32'(req_ready), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_obs();
        run(4);
        check("t5_no_rsp", 32'(rv_cnt), 32'd0);
        new_op(0); new_op(1);
        apply();
        cycle();
        check("t5_first_tie", 32'(last_grant), 32'd0);
        run(8);

        // Random traffic with random backpressure and occasional withdrawn requests
        rr_mode = 1;
        run(400);
        rr_mode = 0;
        p_valid[0] = 0; p_valid[1] = 0;
        rsp_ready = 1'b1;
        apply();
        run(15);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef ALU_SCHED_STATS_EN
        check("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt[0]));
        check("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt[1]));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
